// File: rtl/wdf_stimulus_generator.sv
// rtl/wdf_stimulus_generator.sv - multi-channel, mode-selectable sample stream generator for WDF cores
module wdf_stimulus_generator #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CHANNELS = 2,
    parameter int SAMPLE_DIV   = 2,
    parameter int CNT_WIDTH    = 22,
    parameter int TIMEOUT      = 1024
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               start,
    input  logic                               abort,
    input  logic [3*NUM_CHANNELS-1:0]          mode,
    input  logic [DATA_WIDTH*NUM_CHANNELS-1:0] amplitude,
    input  logic [CNT_WIDTH-1:0]               period,
    input  logic [CNT_WIDTH-1:0]               num_samples,
    output logic [DATA_WIDTH*NUM_CHANNELS-1:0] out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [CNT_WIDTH-1:0]               sample_index,
    output logic                               busy,
    output logic                               done,
    output logic                               timeout_err
);
    localparam int          STALL_W   = $clog2(TIMEOUT + 1);
    localparam int          DIV_W     = $clog2(SAMPLE_DIV + 1);
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state, state_next;

    logic [3*NUM_CHANNELS-1:0]          cfg_mode;
    logic [DATA_WIDTH*NUM_CHANNELS-1:0] cfg_amp;
    logic [CNT_WIDTH-1:0]               cfg_period;
    logic [CNT_WIDTH-1:0]               cfg_num;
    logic [CNT_WIDTH-1:0]               phase;
    logic [DATA_WIDTH-1:0]              ramp_acc [NUM_CHANNELS];
    logic [31:0]                        lfsr;
    logic [STALL_W-1:0]                 stall_cnt;
    logic [DIV_W-1:0]                   div_cnt;

    logic start_ok, transfer, stalled, timeout_hit, last_xfer, phase_wrap;

    // abort outranks everything, including a simultaneous handshake
    assign start_ok    = (state == S_IDLE) && start && !abort;
    assign transfer    = (state == S_RUN) && out_valid && out_ready && !abort;
    assign stalled     = (state == S_RUN) && out_valid && !out_ready && !abort;
    assign timeout_hit = stalled && (stall_cnt == STALL_W'(TIMEOUT - 1));
    assign last_xfer   = transfer && (sample_index == cfg_num - CNT_WIDTH'(1));
    assign phase_wrap  = (cfg_period < CNT_WIDTH'(2)) || (phase + CNT_WIDTH'(1) == cfg_period);

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_next = (num_samples == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (abort || timeout_hit) begin
                    state_next = S_IDLE;
                end else if (last_xfer) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_mode     <= '0;
            cfg_amp      <= '0;
            cfg_period   <= '0;
            cfg_num      <= '0;
            phase        <= '0;
            lfsr         <= LFSR_SEED;
            stall_cnt    <= '0;
            div_cnt      <= '0;
            out_valid    <= 1'b0;
            sample_index <= '0;
            timeout_err  <= 1'b0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                ramp_acc[c] <= '0;
            end
        end else if (start_ok) begin
            cfg_mode     <= mode;
            cfg_amp      <= amplitude;
            cfg_period   <= period;
            cfg_num      <= num_samples;
            phase        <= '0;
            stall_cnt    <= '0;
            div_cnt      <= '0;
            sample_index <= '0;
            timeout_err  <= 1'b0;
            out_valid    <= (num_samples != '0);
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                ramp_acc[c] <= '0;
            end
        end else if (state == S_RUN) begin
            if (abort) begin
                out_valid <= 1'b0;
            end else if (timeout_hit) begin
                out_valid   <= 1'b0;
                timeout_err <= 1'b1;
            end else if (transfer) begin
                sample_index <= sample_index + CNT_WIDTH'(1);
                phase        <= phase_wrap ? '0 : phase + CNT_WIDTH'(1);
                lfsr         <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_POLY : 32'h0);
                stall_cnt    <= '0;
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    ramp_acc[c] <= phase_wrap ? '0
                                 : ramp_acc[c] + cfg_amp[c*DATA_WIDTH +: DATA_WIDTH];
                end
                if (last_xfer) begin
                    out_valid <= 1'b0;
                end else if (SAMPLE_DIV > 1) begin
                    out_valid <= 1'b0;
                    div_cnt   <= DIV_W'(SAMPLE_DIV - 1);
                end
            end else if (stalled) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end else if (!out_valid && (div_cnt != '0)) begin
                // gap after a transfer; the last gap cycle re-presents the next sample
                div_cnt <= div_cnt - DIV_W'(1);
                if (div_cnt == DIV_W'(1)) begin
                    out_valid <= 1'b1;
                end
            end
        end
    end

    logic [DATA_WIDTH-1:0] ch_amp;
    logic [DATA_WIDTH-1:0] ch_val;
    logic [2:0]            ch_mode;

    always_comb begin
        out_data = '0;
        ch_amp   = '0;
        ch_val   = '0;
        ch_mode  = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            ch_amp  = cfg_amp[c*DATA_WIDTH +: DATA_WIDTH];
            ch_mode = cfg_mode[3*c +: 3];
            case (ch_mode)
                3'd1:    ch_val = (sample_index == '0) ? ch_amp : '0;
                3'd2:    ch_val = ch_amp;
                3'd3:    ch_val = ((cfg_period < CNT_WIDTH'(2)) || (phase < (cfg_period >> 1)))
                                  ? ch_amp : -ch_amp;
                3'd4:    ch_val = ramp_acc[c];
                3'd5:    ch_val = lfsr[31 -: DATA_WIDTH];
                default: ch_val = '0;
            endcase
            if (out_valid) begin
                out_data[c*DATA_WIDTH +: DATA_WIDTH] = ch_val;
            end
        end
    end
endmodule

// File: tb/tb_wdf_stimulus_generator.sv
// tb/tb_wdf_stimulus_generator.sv - self-checking bench for wdf_stimulus_generator
module tb_wdf_stimulus_generator;
    localparam int SAMPLE_DIV = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [5:0]  mode;
    logic [31:0] amplitude;
    logic [21:0] period;
    logic [21:0] num_samples;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [21:0] sample_index;
    logic        busy;
    logic        done;
    logic        timeout_err;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mlfsr;
    logic [31:0] obs[$];

    wdf_stimulus_generator dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .mode(mode), .amplitude(amplitude), .period(period), .num_samples(num_samples),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sample_index(sample_index), .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [15:0] model_ch(input logic [2:0] md, input logic [15:0] amp,
                                             input int per, input int n, input logic [31:0] lf);
        int p;
        p = (per < 2) ? 0 : n % per;
        case (md)
            3'd1:    return (n == 0) ? amp : 16'h0;
            3'd2:    return amp;
            3'd3:    return (per < 2 || p < per / 2) ? amp : 16'(~amp + 16'd1);
            3'd4:    return 16'(32'(p) * 32'(amp));
            3'd5:    return lf[31:16];
            default: return 16'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_vec(input logic [5:0] m, input logic [31:0] a,
                                              input int per, input int n, input logic [31:0] lf);
        logic [31:0] v;
        v = '0;
        for (int c = 0; c < 2; c++) begin
            v[c*16 +: 16] = model_ch(m[c*3 +: 3], a[c*16 +: 16], per, n, lf);
        end
        return v;
    endfunction

    task automatic run_check(input logic [5:0] m, input logic [31:0] a, input int per,
                             input int num, input int pct);
        int   n, cyc, last_x;
        logic pv, rdy;
        n = 0; cyc = 0; last_x = 0; pv = 1'b0;
        obs.delete();
        @(negedge clk);
        mode = m; amplitude = a; period = 22'(per); num_samples = 22'(num);
        start = 1'b1; out_ready = 1'b0;
        while (n < num && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                mode = 6'($urandom); amplitude = $urandom;
                period = 22'($urandom_range(0, 9)); num_samples = 22'($urandom_range(0, 3));
                chk("timeout_err_cleared_by_start", timeout_err, 1'b0);
            end
            chk("busy_in_run", busy, 1'b1);
            chk("done_in_run", done, 1'b0);
            if (n > 0 && cyc == last_x + 1) chk("valid_low_after_transfer", out_valid, 1'b0);
            if (out_valid && !pv) chk("valid_spacing", cyc - last_x, (n == 0) ? 1 : SAMPLE_DIV);
            if (out_valid) begin
                chk("sample_index", sample_index, n);
                chk("out_data", out_data, model_vec(m, a, per, n, mlfsr));
            end
            rdy = ($urandom_range(99) < pct);
            out_ready = rdy;
            if (out_valid && rdy) begin
                obs.push_back(out_data);
                n++;
                mlfsr = lfsr_next(mlfsr);
                last_x = cyc;
            end
            pv = out_valid;
        end
        chk("run_completed", n, num);
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse", done, 1'b1);
        chk("valid_in_done", out_valid, 1'b0);
        chk("busy_in_done", busy, 1'b0);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
        out_ready = 1'b0;
    endtask

    logic [31:0] t2_exp [4] = '{32'h7FFF_0100, 32'h0000_0100, 32'h0000_0100, 32'h0000_0100};
    logic [15:0] sq_exp [8] = '{16'd100, 16'd100, 16'hFF9C, 16'hFF9C, 16'd100, 16'd100, 16'hFF9C, 16'hFF9C};
    logic [15:0] rp_exp [8] = '{16'd0, 16'd3, 16'd6, 16'd0, 16'd3, 16'd6, 16'd0, 16'd3};
    logic [31:0] nz_exp [3] = '{32'h0000_0000, 32'h8020_8020, 32'hC030_C030};

    initial begin
        int stall_cycles;
        logic saw_done;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        mode = '0; amplitude = '0; period = '0; num_samples = '0;
        mlfsr = 32'h0000_0001;
        repeat (3) @(negedge clk);
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_sample_index", sample_index, 22'h0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_timeout_err", timeout_err, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        // noise from the reset seed, both channels share one LFSR
        run_check(6'o55, 32'h0, 0, 3, 60);
        for (int i = 0; i < 3; i++) chk("noise_seq", obs[i], nz_exp[i]);

        run_check(6'o12, 32'h7FFF_0100, 0, 4, 100);
        for (int i = 0; i < 4; i++) chk("step_impulse_seq", obs[i], t2_exp[i]);

        for (int pass = 0; pass < 2; pass++) begin
            run_check(6'o43, 32'h0003_0064, 4, 8, (pass == 0) ? 100 : 50);
            for (int i = 0; i < 8; i++) chk("square_seq", obs[i][15:0], sq_exp[i]);
        end
        run_check(6'o43, 32'h0003_0064, 3, 8, 45);
        for (int i = 0; i < 8; i++) chk("ramp_seq", obs[i][31:16], rp_exp[i]);

        run_check(6'o22, 32'h1234_5678, 0, 0, 100);

        // stall timeout
        @(negedge clk);
        mode = 6'o22; amplitude = 32'h0001_0001; num_samples = 22'd3; out_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; stall_cycles = 0; saw_done = 1'b0;
        for (int c = 0; c < 1100 && !timeout_err; c++) begin
            if (out_valid) stall_cycles++;
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        chk("timeout_stall_cycles", stall_cycles, 1024);
        chk("timeout_err_set", timeout_err, 1'b1);
        chk("timeout_valid", out_valid, 1'b0);
        chk("timeout_busy", busy, 1'b0);
        chk("timeout_no_done", saw_done, 1'b0);
        @(negedge clk);
        chk("timeout_err_sticky", timeout_err, 1'b1);
        run_check(6'o12, 32'h0002_0005, 0, 2, 100);

        // abort on sample 2 of 10, with an ignored start while busy
        @(negedge clk);
        mode = 6'o02; amplitude = 32'h0000_0005; period = '0; num_samples = 22'd10;
        out_ready = 1'b1; start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = (c == 2);
            if (c == 2) num_samples = 22'd1;
            if (out_valid && c < 5) mlfsr = lfsr_next(mlfsr);
        end
        chk("abort_pre_valid", out_valid, 1'b1);
        chk("abort_pre_index", sample_index, 22'd2);
        chk("abort_pre_data", out_data, 32'h0000_0005);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", out_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        for (int c = 0; c < 3; c++) begin
            chk("abort_no_done", done, 1'b0);
            @(negedge clk);
        end

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1; num_samples = 22'd5;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 1'b0);
        chk("start_abort_valid", out_valid, 1'b0);
        chk("start_abort_done", done, 1'b0);

        for (int r = 0; r < 6; r++) begin
            run_check(6'($urandom), $urandom, $urandom_range(0, 6),
                      $urandom_range(1, 12), $urandom_range(30, 100));
        end

        // asynchronous reset while a sample is presented
        @(negedge clk);
        mode = 6'o22; amplitude = 32'h00AA_0055; num_samples = 22'd10; out_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("midrun_valid_before_reset", out_valid, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrun_reset_data", out_data, 32'h0);
        chk("midrun_reset_valid", out_valid, 1'b0);
        chk("midrun_reset_busy", busy, 1'b0);
        chk("midrun_reset_done", done, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        mlfsr = 32'h0000_0001;
        @(negedge clk);
        chk("post_reset_busy", busy, 1'b0);
        chk("post_reset_valid", out_valid, 1'b0);
        run_check(6'o55, 32'h0, 0, 3, 100);
        for (int i = 0; i < 3; i++) chk("noise_after_reset", obs[i], nz_exp[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
